// File: rtl/id_stage_pipe.sv
// RV32I integer-ALU decode stage with operand forwarding, load-use stall FSM
// and an internal ID/EX register behind a valid/ready handshake.
`ifndef ID_STAGE_PIPE_DEFS
`define ID_STAGE_PIPE_DEFS
`define AluOpBus    7:0
`define AluSelBus   2:0
`define EXE_NOP_OP  8'b00000000
`define EXE_RES_NOP 3'b000
`define NOPRegAddr  5'b00000
`endif

module id_stage_pipe #(
    parameter int XLEN     = 32,
    parameter int NUM_FWD  = 2,
    parameter int LOAD_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         pc_i,
    input  logic [31:0]             inst_i,
    output logic                    reg1_read_o,
    output logic [4:0]              reg1_addr_o,
    output logic                    reg2_read_o,
    output logic [4:0]              reg2_addr_o,
    input  logic [XLEN-1:0]         reg1_data_i,
    input  logic [XLEN-1:0]         reg2_data_i,
    input  logic [NUM_FWD-1:0]      fwd_wreg_i,
    input  logic [5*NUM_FWD-1:0]    fwd_wd_i,
    input  logic [XLEN*NUM_FWD-1:0] fwd_wdata_i,
    input  logic                    ex_load_i,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         pc_o,
    output logic [`AluOpBus]        aluop_o,
    output logic [`AluSelBus]       alusel_o,
    output logic [XLEN-1:0]         reg1_o,
    output logic [XLEN-1:0]         reg2_o,
    output logic [4:0]              wd_o,
    output logic                    wreg_o,
    output logic                    inst_invalid_o
);

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    localparam logic [`AluOpBus] OP_AND  = 8'b00100100;
    localparam logic [`AluOpBus] OP_OR   = 8'b00100101;
    localparam logic [`AluOpBus] OP_XOR  = 8'b00100110;
    localparam logic [`AluOpBus] OP_SLL  = 8'b01111100;
    localparam logic [`AluOpBus] OP_SRL  = 8'b00000010;
    localparam logic [`AluOpBus] OP_SRA  = 8'b00000011;
    localparam logic [`AluOpBus] OP_SLT  = 8'b00101010;
    localparam logic [`AluOpBus] OP_SLTU = 8'b00101011;
    localparam logic [`AluOpBus] OP_ADD  = 8'b00100000;
    localparam logic [`AluOpBus] OP_SUB  = 8'b00100010;

    localparam logic [`AluSelBus] SEL_LOGIC = 3'b001;
    localparam logic [`AluSelBus] SEL_SHIFT = 3'b010;
    localparam logic [`AluSelBus] SEL_ARITH = 3'b100;

    localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

    typedef enum logic [0:0] {S_RUN, S_STALL} state_t;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rd, rs1, rs2;
    logic [XLEN-1:0] imm_i, imm_u, imm_sh;

    assign opcode = inst_i[6:0];
    assign rd     = inst_i[11:7];
    assign funct3 = inst_i[14:12];
    assign rs1    = inst_i[19:15];
    assign rs2    = inst_i[24:20];
    assign funct7 = inst_i[31:25];
    assign imm_i  = XLEN'($signed(inst_i[31:20]));
    assign imm_u  = XLEN'($signed({inst_i[31:12], 12'b0}));
    assign imm_sh = XLEN'(inst_i[24:20]);

    logic [`AluOpBus]  dec_aluop;
    logic [`AluSelBus] dec_alusel;
    logic              dec_wreg, dec_re1, dec_re2, dec_use_pc, dec_ok;
    logic [XLEN-1:0]   dec_imm;

    always_comb begin
        dec_aluop  = `EXE_NOP_OP;
        dec_alusel = `EXE_RES_NOP;
        dec_wreg   = 1'b0;
        dec_re1    = 1'b0;
        dec_re2    = 1'b0;
        dec_use_pc = 1'b0;
        dec_ok     = 1'b0;
        dec_imm    = '0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                dec_ok     = 1'b1;
                dec_wreg   = 1'b1;
                dec_aluop  = OP_ADD;
                dec_alusel = SEL_ARITH;
                dec_imm    = imm_u;
                dec_use_pc = (opcode == OPC_AUIPC);
            end
            OPC_OPIMM: begin
                dec_wreg = 1'b1;
                dec_re1  = 1'b1;
                dec_imm  = imm_i;
                case (funct3)
                    3'b000: begin dec_ok = 1'b1; dec_aluop = OP_ADD;  dec_alusel = SEL_ARITH; end
                    3'b010: begin dec_ok = 1'b1; dec_aluop = OP_SLT;  dec_alusel = SEL_ARITH; end
                    3'b011: begin dec_ok = 1'b1; dec_aluop = OP_SLTU; dec_alusel = SEL_ARITH; end
                    3'b100: begin dec_ok = 1'b1; dec_aluop = OP_XOR;  dec_alusel = SEL_LOGIC; end
                    3'b110: begin dec_ok = 1'b1; dec_aluop = OP_OR;   dec_alusel = SEL_LOGIC; end
                    3'b111: begin dec_ok = 1'b1; dec_aluop = OP_AND;  dec_alusel = SEL_LOGIC; end
                    3'b001: begin
                        dec_imm    = imm_sh;
                        dec_ok     = (funct7 == F7_BASE);
                        dec_aluop  = OP_SLL;
                        dec_alusel = SEL_SHIFT;
                    end
                    3'b101: begin
                        dec_imm    = imm_sh;
                        dec_ok     = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                        dec_aluop  = (funct7 == F7_ALT) ? OP_SRA : OP_SRL;
                        dec_alusel = SEL_SHIFT;
                    end
                endcase
            end
            OPC_OP: begin
                dec_wreg = 1'b1;
                dec_re1  = 1'b1;
                dec_re2  = 1'b1;
                dec_ok   = (funct7 == F7_BASE);
                case (funct3)
                    3'b000: begin
                        dec_ok     = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                        dec_aluop  = (funct7 == F7_ALT) ? OP_SUB : OP_ADD;
                        dec_alusel = SEL_ARITH;
                    end
                    3'b001: begin dec_aluop = OP_SLL;  dec_alusel = SEL_SHIFT; end
                    3'b010: begin dec_aluop = OP_SLT;  dec_alusel = SEL_ARITH; end
                    3'b011: begin dec_aluop = OP_SLTU; dec_alusel = SEL_ARITH; end
                    3'b100: begin dec_aluop = OP_XOR;  dec_alusel = SEL_LOGIC; end
                    3'b101: begin
                        dec_ok     = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                        dec_aluop  = (funct7 == F7_ALT) ? OP_SRA : OP_SRL;
                        dec_alusel = SEL_SHIFT;
                    end
                    3'b110: begin dec_aluop = OP_OR;   dec_alusel = SEL_LOGIC; end
                    3'b111: begin dec_aluop = OP_AND;  dec_alusel = SEL_LOGIC; end
                endcase
            end
            default: ;
        endcase
        // Unsupported encodings read nothing, so they can never raise a false hazard.
        if (!dec_ok) begin
            dec_aluop  = `EXE_NOP_OP;
            dec_alusel = `EXE_RES_NOP;
            dec_wreg   = 1'b0;
            dec_re1    = 1'b0;
            dec_re2    = 1'b0;
            dec_use_pc = 1'b0;
            dec_imm    = '0;
        end
    end

    // x0 always reads zero; otherwise the youngest matching writer wins over the regfile.
    function automatic logic [XLEN-1:0] pick_operand(
        input logic [4:0]              addr,
        input logic [XLEN-1:0]         rf_data,
        input logic [NUM_FWD-1:0]      we,
        input logic [5*NUM_FWD-1:0]    wd,
        input logic [XLEN*NUM_FWD-1:0] wdata
    );
        logic [XLEN-1:0] v;
        v = rf_data;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (we[i] && (wd[5*i +: 5] == addr)) v = wdata[XLEN*i +: XLEN];
        end
        if (addr == 5'd0) v = '0;
        return v;
    endfunction

    logic [XLEN-1:0] op1, op2;
    logic [4:0]      ex_wd;
    logic            hazard;

    assign op1 = dec_re1 ? pick_operand(rs1, reg1_data_i, fwd_wreg_i, fwd_wd_i, fwd_wdata_i)
                         : (dec_use_pc ? pc_i : '0);
    assign op2 = dec_re2 ? pick_operand(rs2, reg2_data_i, fwd_wreg_i, fwd_wd_i, fwd_wdata_i)
                         : dec_imm;

    assign reg1_read_o = in_valid & dec_re1;
    assign reg2_read_o = in_valid & dec_re2;
    assign reg1_addr_o = in_valid ? rs1 : 5'd0;
    assign reg2_addr_o = in_valid ? rs2 : 5'd0;

    assign ex_wd  = fwd_wd_i[4:0];
    assign hazard = in_valid && ex_load_i && fwd_wreg_i[0] && (ex_wd != 5'd0) &&
                    ((dec_re1 && (ex_wd == rs1)) || (dec_re2 && (ex_wd == rs2)));

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       in_ready_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The hazard cycle itself is the first bubble; STALL only covers the extra LOAD_LAT-1 cycles.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        in_ready_c = 1'b0;
        case (state_q)
            S_RUN: begin
                if (hazard) begin
                    if (LOAD_LAT > 1) begin
                        state_d = S_STALL;
                        cnt_d   = LAT_M1;
                    end
                end else begin
                    in_ready_c = !out_valid || out_ready;
                end
            end
            S_STALL: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = S_RUN;
                    cnt_d   = 3'd0;
                end
            end
            default: state_d = S_RUN;
        endcase
        if (flush) begin
            state_d = S_RUN;
            cnt_d   = 3'd0;
        end
    end

    assign in_ready = in_ready_c;

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   pc_q, pc_d, reg1_q, reg1_d, reg2_q, reg2_d;
    logic [`AluOpBus]  aluop_q, aluop_d;
    logic [`AluSelBus] alusel_q, alusel_d;
    logic [4:0]        wd_q, wd_d;
    logic              wreg_q, wreg_d, inv_q, inv_d;

    always_comb begin
        valid_d  = valid_q;
        pc_d     = pc_q;
        reg1_d   = reg1_q;
        reg2_d   = reg2_q;
        aluop_d  = aluop_q;
        alusel_d = alusel_q;
        wd_d     = wd_q;
        wreg_d   = wreg_q;
        inv_d    = inv_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (in_valid && in_ready_c) begin
            valid_d  = 1'b1;
            pc_d     = pc_i;
            reg1_d   = op1;
            reg2_d   = op2;
            aluop_d  = dec_aluop;
            alusel_d = dec_alusel;
            wd_d     = dec_ok ? rd : `NOPRegAddr;
            wreg_d   = dec_wreg;
            inv_d    = !dec_ok;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            reg1_q   <= '0;
            reg2_q   <= '0;
            aluop_q  <= `EXE_NOP_OP;
            alusel_q <= `EXE_RES_NOP;
            wd_q     <= `NOPRegAddr;
            wreg_q   <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            reg1_q   <= reg1_d;
            reg2_q   <= reg2_d;
            aluop_q  <= aluop_d;
            alusel_q <= alusel_d;
            wd_q     <= wd_d;
            wreg_q   <= wreg_d;
            inv_q    <= inv_d;
        end
    end

    assign out_valid      = valid_q;
    assign pc_o           = pc_q;
    assign reg1_o         = reg1_q;
    assign reg2_o         = reg2_q;
    assign aluop_o        = aluop_q;
    assign alusel_o       = alusel_q;
    assign wd_o           = wd_q;
    assign wreg_o         = wreg_q;
    assign inst_invalid_o = inv_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: a default instance plus a LOAD_LAT=3 instance on shared inputs.
module tb_id_stage_pipe;
    localparam logic [7:0] A_ADD = 8'h20, A_XOR = 8'h26, A_OR = 8'h25, A_AND = 8'h24, A_SRA = 8'h03;

    logic        clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0, ex_load = 1'b0;
    logic [31:0] pc = '0, inst = '0, r1d = '0, r2d = '0;
    logic [1:0]  fwe = '0;
    logic [9:0]  fwd = '0;
    logic [63:0] fwdata = '0;

    logic        in_ready, r1re, r2re, out_valid, wreg_o, inv;
    logic [4:0]  r1a, r2a, wd_o;
    logic [31:0] pc_o, reg1_o, reg2_o;
    logic [7:0]  aluop;
    logic [2:0]  alusel;

    logic        l3_in_ready, l3_r1re, l3_r2re, l3_out_valid, l3_wreg, l3_inv;
    logic [4:0]  l3_r1a, l3_r2a, l3_wd;
    logic [31:0] l3_pc, l3_reg1, l3_reg2;
    logic [7:0]  l3_aluop;
    logic [2:0]  l3_alusel;

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    id_stage_pipe dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .pc_i(pc), .inst_i(inst), .reg1_read_o(r1re), .reg1_addr_o(r1a),
        .reg2_read_o(r2re), .reg2_addr_o(r2a), .reg1_data_i(r1d), .reg2_data_i(r2d),
        .fwd_wreg_i(fwe), .fwd_wd_i(fwd), .fwd_wdata_i(fwdata), .ex_load_i(ex_load),
        .out_valid(out_valid), .out_ready(out_ready), .pc_o(pc_o), .aluop_o(aluop),
        .alusel_o(alusel), .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o),
        .wreg_o(wreg_o), .inst_invalid_o(inv)
    );

    id_stage_pipe #(.LOAD_LAT(3)) dut_l3 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(l3_in_ready),
        .pc_i(pc), .inst_i(inst), .reg1_read_o(l3_r1re), .reg1_addr_o(l3_r1a),
        .reg2_read_o(l3_r2re), .reg2_addr_o(l3_r2a), .reg1_data_i(r1d), .reg2_data_i(r2d),
        .fwd_wreg_i(fwe), .fwd_wd_i(fwd), .fwd_wdata_i(fwdata), .ex_load_i(ex_load),
        .out_valid(l3_out_valid), .out_ready(out_ready), .pc_o(l3_pc), .aluop_o(l3_aluop),
        .alusel_o(l3_alusel), .reg1_o(l3_reg1), .reg2_o(l3_reg2), .wd_o(l3_wd),
        .wreg_o(l3_wreg), .inst_invalid_o(l3_inv)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h want=0", out_valid); end
        total++; if (wreg_o !== 1'b0) begin bad++; $display("FAIL rst_wreg got=%0h want=0", wreg_o); end
        total++; if (inv !== 1'b0) begin bad++; $display("FAIL rst_invalid got=%0h want=0", inv); end
        total++; if (aluop !== 8'h00 || alusel !== 3'd0) begin bad++; $display("FAIL rst_op got=%0h/%0h want=0/0", aluop, alusel); end
        total++; if (pc_o !== 32'h0 || reg1_o !== 32'h0 || reg2_o !== 32'h0 || wd_o !== 5'd0) begin
            bad++; $display("FAIL rst_data got pc=%0h r1=%0h r2=%0h wd=%0h want all 0", pc_o, reg1_o, reg2_o, wd_o); end
        total++; if (in_ready !== 1'b1 || l3_in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0h/%0h want=1/1", in_ready, l3_in_ready); end
        rst = 1'b1;
    endtask

    task automatic test_addi();
        pc = 32'h100; inst = 32'hFFB00093; in_valid = 1'b1; out_ready = 1'b1; r1d = 32'hAAAA; r2d = 32'hBBBB;
        #1;
        total++; if (r1re !== 1'b1 || r1a !== 5'd0 || r2re !== 1'b0) begin bad++; $display("FAIL addi_rdport got=%0h/%0h/%0h want=1/0/0", r1re, r1a, r2re); end
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || wreg_o !== 1'b1 || wd_o !== 5'd1) begin bad++; $display("FAIL addi_ctl got v=%0h w=%0h wd=%0h want 1/1/1", out_valid, wreg_o, wd_o); end
        total++; if (reg1_o !== 32'h0 || reg2_o !== 32'hFFFFFFFB) begin bad++; $display("FAIL addi_ops got=%0h/%0h want=0/fffffffb", reg1_o, reg2_o); end
        total++; if (aluop !== A_ADD || alusel !== 3'd4 || pc_o !== 32'h100) begin bad++; $display("FAIL addi_op got=%0h/%0h/%0h want=20/4/100", aluop, alusel, pc_o); end
        #1;
        total++; if (r1re !== 1'b0 || r1a !== 5'd0) begin bad++; $display("FAIL idle_rdport got=%0h/%0h want=0/0", r1re, r1a); end
    endtask

    task automatic test_fwd();
        inst = 32'h002081B3; in_valid = 1'b1; r1d = 32'd7; r2d = 32'd9;
        fwe = 2'b11; fwd = {5'd1, 5'd1}; fwdata = {32'h22, 32'h11};
        #1;
        total++; if (r2re !== 1'b1 || r2a !== 5'd2) begin bad++; $display("FAIL add_rdport got=%0h/%0h want=1/2", r2re, r2a); end
        tick();
        total++; if (reg1_o !== 32'h11 || reg2_o !== 32'd9 || wd_o !== 5'd3) begin bad++; $display("FAIL fwd_prio got=%0h/%0h/%0h want=11/9/3", reg1_o, reg2_o, wd_o); end
        fwe = 2'b10; fwd = {5'd2, 5'd1}; fwdata = {32'h33, 32'h11};
        tick();
        total++; if (reg1_o !== 32'd7 || reg2_o !== 32'h33) begin bad++; $display("FAIL fwd_src1 got=%0h/%0h want=7/33", reg1_o, reg2_o); end
        in_valid = 1'b0; fwe = 2'b00;
    endtask

    task automatic test_load_use();
        ex_load = 1'b1; fwe = 2'b01; fwd = {5'd0, 5'd5}; fwdata = {32'h0, 32'hBAD};
        inst = 32'h0002C333; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0 || l3_in_ready !== 1'b0) begin bad++; $display("FAIL lu_ready0 got=%0h/%0h want=0/0", in_ready, l3_in_ready); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble got=%0h want=0", out_valid); end
        ex_load = 1'b0; fwe = 2'b10; fwd = {5'd5, 5'd0}; fwdata = {32'h55, 32'h0};
        #1;
        total++; if (in_ready !== 1'b1 || l3_in_ready !== 1'b0) begin bad++; $display("FAIL lu_ready1 got=%0h/%0h want=1/0", in_ready, l3_in_ready); end
        tick();
        total++; if (out_valid !== 1'b1 || reg1_o !== 32'h55 || reg2_o !== 32'h0) begin bad++; $display("FAIL lu_redecode got v=%0h r1=%0h r2=%0h want 1/55/0", out_valid, reg1_o, reg2_o); end
        total++; if (aluop !== A_XOR || wd_o !== 5'd6) begin bad++; $display("FAIL lu_op got=%0h/%0h want=26/6", aluop, wd_o); end
        total++; if (l3_in_ready !== 1'b0 || l3_out_valid !== 1'b0) begin bad++; $display("FAIL l3_stall2 got=%0h/%0h want=0/0", l3_in_ready, l3_out_valid); end
        tick();
        total++; if (l3_in_ready !== 1'b1 || l3_out_valid !== 1'b0) begin bad++; $display("FAIL l3_stall3 got=%0h/%0h want=1/0", l3_in_ready, l3_out_valid); end
        tick();
        total++; if (l3_out_valid !== 1'b1 || l3_reg1 !== 32'h55) begin bad++; $display("FAIL l3_accept got=%0h/%0h want=1/55", l3_out_valid, l3_reg1); end
        in_valid = 1'b0; fwe = 2'b00;
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; inst = 32'h0F00E393; in_valid = 1'b1; r1d = 32'd7;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_empty got=%0h want=1", in_ready); end
        tick();
        inst = 32'hFFF17413;
        for (int k = 0; k < 3; k++) begin
            total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold%0d got rdy=%0h v=%0h want 0/1", k, in_ready, out_valid); end
            total++; if (reg1_o !== 32'd7 || reg2_o !== 32'hF0 || wd_o !== 5'd7 || aluop !== A_OR) begin
                bad++; $display("FAIL bp_data%0d got r1=%0h r2=%0h wd=%0h op=%0h want 7/f0/7/25", k, reg1_o, reg2_o, wd_o, aluop); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%0h want=1", in_ready); end
        tick();
        total++; if (wd_o !== 5'd8 || reg2_o !== 32'hFFFFFFFF || aluop !== A_AND || alusel !== 3'd1) begin
            bad++; $display("FAIL bp_next got wd=%0h r2=%0h op=%0h sel=%0h want 8/ffffffff/24/1", wd_o, reg2_o, aluop, alusel); end
        in_valid = 1'b0;
    endtask

    task automatic test_invalid();
        out_ready = 1'b1; in_valid = 1'b1; inst = 32'h2030D213;
        tick();
        total++; if (inv !== 1'b1 || wreg_o !== 1'b0 || aluop !== 8'h00 || out_valid !== 1'b1) begin
            bad++; $display("FAIL inv_srli got inv=%0h w=%0h op=%0h v=%0h want 1/0/0/1", inv, wreg_o, aluop, out_valid); end
        inst = 32'h4030D213;
        tick();
        total++; if (inv !== 1'b0 || wreg_o !== 1'b1 || aluop !== A_SRA || reg2_o !== 32'd3 || alusel !== 3'd2) begin
            bad++; $display("FAIL srai got inv=%0h w=%0h op=%0h r2=%0h sel=%0h want 0/1/3/3/2", inv, wreg_o, aluop, reg2_o, alusel); end
        inst = 32'h0000000B;
        #1;
        total++; if (r1re !== 1'b0 || r2re !== 1'b0) begin bad++; $display("FAIL inv_noread got=%0h/%0h want=0/0", r1re, r2re); end
        tick();
        total++; if (inv !== 1'b1 || wreg_o !== 1'b0) begin bad++; $display("FAIL inv_opc got=%0h/%0h want=1/0", inv, wreg_o); end
        inst = 32'h00100493; fwe = 2'b01; fwd = {5'd0, 5'd0}; fwdata = {32'h0, 32'hDEAD}; ex_load = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL x0_nohazard got=%0h want=1", in_ready); end
        tick();
        total++; if (reg1_o !== 32'h0 || reg2_o !== 32'd1 || wd_o !== 5'd9) begin bad++; $display("FAIL x0_fwd got=%0h/%0h/%0h want=0/1/9", reg1_o, reg2_o, wd_o); end
        ex_load = 1'b0; fwe = 2'b00; pc = 32'h200; inst = 32'h12345537;
        tick();
        total++; if (reg1_o !== 32'h0 || reg2_o !== 32'h12345000 || wd_o !== 5'd10) begin bad++; $display("FAIL lui got=%0h/%0h/%0h want=0/12345000/a", reg1_o, reg2_o, wd_o); end
        inst = 32'h00001597;
        tick();
        total++; if (reg1_o !== 32'h200 || reg2_o !== 32'h1000 || aluop !== A_ADD) begin bad++; $display("FAIL auipc got=%0h/%0h/%0h want=200/1000/20", reg1_o, reg2_o, aluop); end
        in_valid = 1'b0;
    endtask

    task automatic test_flush();
        ex_load = 1'b1; fwe = 2'b01; fwd = {5'd0, 5'd5}; inst = 32'h0002C333; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b1; ex_load = 1'b0; fwe = 2'b00;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || l3_out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0h/%0h want=0/0", out_valid, l3_out_valid); end
        total++; if (in_ready !== 1'b1 || l3_in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%0h/%0h want=1/1", in_ready, l3_in_ready); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1; inst = 32'h0F00E393;
        tick();
        ex_load = 1'b1; fwe = 2'b01; fwd = {5'd0, 5'd5}; inst = 32'h0002C333;
        tick();
        total++; if (out_valid !== 1'b1 || l3_in_ready !== 1'b0) begin bad++; $display("FAIL pre_rst got=%0h/%0h want=1/0", out_valid, l3_in_ready); end
        #2 rst = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || l3_out_valid !== 1'b0 || wd_o !== 5'd0 || aluop !== 8'h00) begin
            bad++; $display("FAIL midrst got v=%0h l3v=%0h wd=%0h op=%0h want 0/0/0/0", out_valid, l3_out_valid, wd_o, aluop); end
        ex_load = 1'b0; fwe = 2'b00; in_valid = 1'b0;
        rst = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1 || l3_in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%0h/%0h want=1/1", in_ready, l3_in_ready); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_fwd();
        test_load_use();
        test_backpressure();
        test_invalid();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Registered, parametrised RV32I decode stage.
- Sits between the IF/ID register and EX, and holds the ID/EX pipeline register internally.
- Decodes the RV32I integer-ALU subset, reads the regfile, and forwards from NUM_FWD downstream write sources in priority order.
- Detects load-use hazards and inserts bubbles through a small stall FSM with a valid/ready handshake on both sides.

Parameters:
- XLEN, 32, datapath width.
- NUM_FWD, 2, number of forwarding sources; index 0 = youngest (EX), highest priority.
- LOAD_LAT, 1, bubble cycles inserted per load-use hazard (1..7).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous kill of ID/EX contents and stall state.
- in_valid  in  1  pc_i/inst_i valid.
- in_ready  out  1  stage accepts the instruction this cycle.
- pc_i  in  XLEN  instruction address.
- inst_i  in  32  instruction.
- reg1_read_o  out  1  rs1 used (combinational).
- reg1_addr_o  out  5  rs1 address (combinational).
- reg2_read_o  out  1  rs2 used (combinational).
- reg2_addr_o  out  5  rs2 address (combinational).
- reg1_data_i  in  XLEN  regfile read port 1 data.
- reg2_data_i  in  XLEN  regfile read port 2 data.
- fwd_wreg_i  in  NUM_FWD  per-source write enable.
- fwd_wd_i  in  5*NUM_FWD  per-source destination register.
- fwd_wdata_i  in  XLEN*NUM_FWD  per-source write data.
- ex_load_i  in  1  instruction in source 0 is a load (its data is not yet valid).
- out_valid  out  1  ID/EX register holds a valid instruction.
- out_ready  in  1  EX accepts.
- pc_o  out  XLEN  registered pc.
- aluop_o  out  `AluOpBus  registered ALU op.
- alusel_o  out  `AluSelBus  registered ALU class.
- reg1_o  out  XLEN  registered operand 1.
- reg2_o  out  XLEN  registered operand 2.
- wd_o  out  5  registered destination register.
- wreg_o  out  1  registered write enable.
- inst_invalid_o  out  1  registered flag: instruction not in the decoded subset.

Behaviour:
- Reset (rst=0, async):
  - out_valid=0, wreg_o=0, inst_invalid_o=0.
  - aluop_o=`EXE_NOP_OP, alusel_o=`EXE_RES_NOP.
  - pc_o, reg1_o, reg2_o = 0; wd_o=`NOPRegAddr.
  - FSM to RUN, bubble counter 0.
- Decoded subset:
  - LUI: reg1 = 0, reg2 = imm<<12.
  - AUIPC: reg1 = pc, reg2 = imm<<12.
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI.
  - SLLI, SRLI, SRAI: funct7 must be 0000000 / 0100000, otherwise invalid.
  - ADD/SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL/SRA.
- I-type immediates are sign-extended from inst[31]. Shift immediates are zero-extended inst[24:20].
- Invalid instruction: wreg_o=0, aluop NOP, inst_invalid_o=1, still passes through the handshake.
- reg_read/addr outputs:
  - Driven combinationally from inst_i whenever in_valid.
  - When !in_valid, read=0 and addr=0.
- Operand selection per source (rs1, rs2), first match wins:
  1. Address x0 → 0.
  2. Lowest index i with fwd_wreg_i[i] && fwd_wd_i[i]==addr → fwd_wdata_i[i].
  3. Regfile data.
  4. If the operand is unused → immediate (reg2) or 0/pc (reg1).
- Hazard: in_valid && ex_load_i && fwd_wreg_i[0] && fwd_wd_i[0]!=0 && fwd_wd_i[0] matches a used rs1/rs2.
- FSM:
  - RUN:
    - hazard → go to STALL, load counter = LOAD_LAT-1, in_ready=0.
    - otherwise in_ready = !out_valid || out_ready.
  - STALL:
    - in_ready=0.
    - When the downstream slot frees, the ID/EX register loads a bubble (out_valid=0).
    - Counter decrements each cycle; at 0 return to RUN.
    - The held instruction is re-decoded with fresh forwarding on the RUN cycle.
- Register update, priority order:
  1. flush → out_valid=0, FSM to RUN.
  2. in_valid && in_ready → load decoded fields, out_valid=1.
  3. out_ready → out_valid=0.
  4. Else hold all outputs unchanged (backpressure).
- Latency is 1 cycle from acceptance to out_valid.
- Simultaneous flush and acceptance: flush wins and the instruction is dropped. Upstream must treat in_ready as consumed.
- Reset asserted mid-stall aborts the stall with no bubble left pending.

Test Plan:
- Reset, then ADDI x1,x0,-5 (0xFFB00093) with out_ready=1 → next cycle out_valid=1, wd_o=1, wreg_o=1, reg1_o=0, reg2_o=0xFFFFFFFB.
- ADD x3,x1,x2 with regfile returning 7/9, fwd0 writes x1=0x11, fwd1 writes x1=0x22 and x2=0x33 → reg1_o=0x11, reg2_o=0x33.
- ex_load_i=1, fwd_wd_i[0]=5, then XOR x6,x5,x0 → in_ready=0 for LOAD_LAT cycles and one out_valid=0 bubble; then reg1_o = the fwd1 value of x5.
- out_ready=0 for 3 cycles while ORI is held → outputs stable, in_ready=0; releasing out_ready accepts the next instruction the same cycle.
- SRLI with funct7=0x10, and opcode 0x0B → inst_invalid_o=1, wreg_o=0. Forwarding to x0 (fwd_wd=0, data 0xDEAD) → operand 0.
- flush during STALL, and rst pulled low mid-backpressure → out_valid=0 on the next edge (flush) or immediately (rst); FSM in RUN; in_ready=1.
